// File: rtl/tercer_nivel_pkg.sv
// Shared types and encodings for the third-level cache controller.
package tercer_nivel_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    EVICT,
    FILL,
    FILL_WR,
    WRITE,
    RESPOND
  } state_t;

  // Encoding doubles as the lectura_escritura mux select
  typedef enum logic {
    SRC_CPU  = 1'b0,
    SRC_FIFO = 1'b1
  } src_t;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

endpackage

// File: rtl/tercer_nivel_arb.sv
// Two-way round-robin arbiter between CPU requests and D_POP write-backs.
module tercer_nivel_arb
  import tercer_nivel_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_fifo,
  input  logic grant_en,
  output logic grant_valid,
  output src_t grant_src
);

  src_t last_served;

  always_comb begin
    grant_valid = req_cpu || req_fifo;
    if (req_cpu && req_fifo)
      grant_src = (last_served == SRC_CPU) ? SRC_FIFO : SRC_CPU;
    else if (req_fifo)
      grant_src = SRC_FIFO;
    else
      grant_src = SRC_CPU;
  end

  // Starting from "CPU served last" hands the first tie to the FIFO
  always_ff @(posedge clk) begin
    if (reset)
      last_served <= SRC_CPU;
    else if (grant_en && grant_valid)
      last_served <= grant_src;
  end

endmodule

// File: rtl/tercer_nivel_control.sv
// Sequencing controller for the L3 cache datapath: arbitrates CPU vs. D_POP
// and drives the hit / evict / fill / write / respond control strobes.
module tercer_nivel_control
  import tercer_nivel_pkg::*;
#(
  parameter int MEM_LAT    = 4,
  parameter int CLR_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic       hit,
  input  logic       desalojo,
  input  logic       push_full,
  output logic       push,
  output logic       cpu_done,
  output logic       busy,
  output logic       lectura_escritura,
  output logic       clear_main_reg,
  output logic       clear_tag_banks,
  output logic       clear_formador,
  output logic       clear_ldg_reg,
  output logic       eneable_main_reg,
  output logic       eneable_formador,
  output logic       bank_eneable,
  output logic       write_eneable,
  output logic       eneable_reg,
  output logic       sel_mux_bank,
  output logic [1:0] sel_mux_mem,
  output logic       r_w
);

  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
  localparam int FILL_W = $clog2(MEM_LAT + 1);

  state_t            state;
  src_t              src;
  logic              rw_q;
  logic [CLR_W-1:0]  clr_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic              grant_valid;
  src_t              grant_src;
  logic              src_is_fifo;

  assign src_is_fifo = (src == SRC_FIFO);

  tercer_nivel_arb u_arb (
    .clk         (CLK),
    .reset       (Reset),
    .req_cpu     (cpu_req),
    .req_fifo    (!fifo_empty),
    .grant_en    ((state == IDLE) && !Reset),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= INIT;
      clr_cnt  <= CLR_W'(CLR_CYCLES - 1);
      fill_cnt <= '0;
      src      <= SRC_CPU;
      rw_q     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == '0)
            state <= IDLE;
          else
            clr_cnt <= clr_cnt - 1'b1;
        end
        IDLE: begin
          if (grant_valid) begin
            src   <= grant_src;
            rw_q  <= (grant_src == SRC_FIFO) ? 1'b1 : cpu_rw;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= rw_q ? WRITE : RESPOND;
          end else if (desalojo) begin
            state <= EVICT;
          end else begin
            state    <= FILL;
            fill_cnt <= FILL_W'(MEM_LAT - 1);
          end
        end
        // Stalls indefinitely while the downstream FIFO is full
        EVICT: begin
          if (!push_full) begin
            state    <= FILL;
            fill_cnt <= FILL_W'(MEM_LAT - 1);
          end
        end
        FILL: begin
          if (fill_cnt == '0)
            state <= FILL_WR;
          else
            fill_cnt <= fill_cnt - 1'b1;
        end
        FILL_WR: state <= LOOKUP;
        WRITE:   state <= RESPOND;
        RESPOND: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  // Reset overrides the state decode so no handshake strobe leaks in that cycle
  always_comb begin
    fifo_pop          = 1'b0;
    push              = 1'b0;
    cpu_done          = 1'b0;
    busy              = 1'b0;
    lectura_escritura = 1'b0;
    clear_main_reg    = 1'b0;
    clear_tag_banks   = 1'b0;
    clear_formador    = 1'b0;
    clear_ldg_reg     = 1'b0;
    eneable_main_reg  = 1'b0;
    eneable_formador  = 1'b0;
    bank_eneable      = 1'b0;
    write_eneable     = 1'b0;
    eneable_reg       = 1'b0;
    sel_mux_bank      = 1'b0;
    sel_mux_mem       = MEM_IDLE;
    r_w               = 1'b0;
    if (Reset) begin
      clear_main_reg  = 1'b1;
      clear_tag_banks = 1'b1;
      clear_formador  = 1'b1;
      clear_ldg_reg   = 1'b1;
    end else begin
      case (state)
        INIT: begin
          busy            = 1'b1;
          clear_main_reg  = 1'b1;
          clear_tag_banks = 1'b1;
          clear_formador  = 1'b1;
          clear_ldg_reg   = 1'b1;
        end
        IDLE: begin
          if (grant_valid) begin
            eneable_main_reg  = 1'b1;
            lectura_escritura = (grant_src == SRC_FIFO);
            fifo_pop          = (grant_src == SRC_FIFO);
          end
        end
        LOOKUP: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          clear_formador    = !hit && !desalojo;
        end
        EVICT: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          sel_mux_mem       = MEM_WR;
          r_w               = 1'b1;
          push              = !push_full;
          clear_formador    = !push_full;
        end
        FILL: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          sel_mux_mem       = MEM_RD;
          eneable_formador  = 1'b1;
        end
        FILL_WR: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          sel_mux_bank      = 1'b1;
          bank_eneable      = 1'b1;
          write_eneable     = 1'b1;
        end
        WRITE: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          bank_eneable      = 1'b1;
          write_eneable     = 1'b1;
        end
        RESPOND: begin
          busy              = 1'b1;
          lectura_escritura = src_is_fifo;
          eneable_reg       = 1'b1;
          cpu_done          = !src_is_fifo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tercer_nivel_control.md
Name: tercer_nivel_control

Overview:
- Sequencing controller for the third-level cache datapath.
- Arbitrates between CPU requests (DatoEntrada/Address path) and L2 write-backs arriving on the D_POP FIFO.
- Drives every datapath control strobe: input mux select, main/tag/formador/LDG register clears and enables, bank and memory muxes, bank write.
- Runs the hit / evict / fill / write / respond sequence from the datapath's Hit and Desalojo flags.

Parameters:
- MEM_LAT, 4, cycles the formador assembles a line from memory during a fill (≥1).
- CLR_CYCLES, 4, cycles the clear strobes stay asserted after reset (≥1).

Ports:
- CLK  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access pending; held high until cpu_done.
- cpu_rw  in  1  0=read, 1=write; sampled at grant.
- fifo_empty  in  1  D_POP FIFO empty.
- fifo_pop  out  1  one-cycle pop of the D_POP FIFO.
- hit  in  1  datapath Hit.
- desalojo  in  1  datapath Desalojo (dirty victim).
- push_full  in  1  downstream D_PUSH FIFO full.
- push  out  1  D_PUSH write strobe.
- cpu_done  out  1  one-cycle completion of a CPU access.
- busy  out  1  high in every state except IDLE.
- lectura_escritura  out  1  input mux select: 0=CPU, 1=D_POP.
- clear_main_reg, clear_tag_banks, clear_formador, clear_ldg_reg  out  1 each  datapath clears.
- eneable_main_reg, eneable_formador, bank_eneable, write_eneable, eneable_reg  out  1 each  datapath enables.
- sel_mux_bank  out  1  bank data select: 0=main reg, 1=formador.
- sel_mux_mem  out  2  memory path: 00 idle, 01 memory read, 10 main-reg write.
- r_w  out  1  memory direction: 0=read, 1=write.

Behaviour:
- Reset, sampled on the CLK edge and effective from any state:
  - Next state is INIT; the CLR_CYCLES counter loads.
  - fifo_pop, push and cpu_done are never asserted in the reset cycle.
  - All outputs are 0 except the four clears, which are 1.
- INIT: the four clears stay high for CLR_CYCLES cycles, then the block goes to IDLE. Requests are ignored during INIT.
- IDLE, arbitration (two-way round-robin):
  - If only one source is pending, it is granted.
  - If CPU and FIFO are both pending, the source not served last is granted; the first grant after reset goes to FIFO.
  - In the grant cycle: eneable_main_reg=1 and lectura_escritura = granted source. fifo_pop=1 if FIFO was granted. The source, and rw (FIFO is always a write), are latched. Next state is LOOKUP.
- lectura_escritura holds the latched source from grant until return to IDLE.
- LOOKUP:
  - hit and read → RESPOND.
  - hit and write → WRITE.
  - !hit and desalojo → EVICT.
  - !hit and !desalojo → FILL.
- EVICT: sel_mux_mem=10, r_w=1. push=1 only when !push_full. After the cycle in which push=1, go to FILL. While the FIFO is full the block stalls with no timeout.
- FILL:
  - sel_mux_mem=01, r_w=0, eneable_formador=1 for exactly MEM_LAT cycles, then FILL_WR.
  - clear_formador=1 in the cycle entering FILL.
- FILL_WR: sel_mux_bank=1, bank_eneable=1, write_eneable=1 for one cycle, then LOOKUP. The retried lookup hits.
- WRITE: sel_mux_bank=0, bank_eneable=1, write_eneable=1 for one cycle, then RESPOND.
- RESPOND:
  - eneable_reg=1.
  - cpu_done=1 only when the source is CPU; a FIFO write-back completes silently.
  - Next state is IDLE.
- Latency from the grant cycle (cycle 0), MEM_LAT=4:
  - read hit: cpu_done at cycle 2.
  - write hit: cpu_done at cycle 3.
  - clean read miss: cpu_done at cycle 8.
  - dirty read miss, push_full low: cpu_done at cycle 9.
- Every strobe is 0 outside the states listed above. Only one source is in service at a time.

Decomposition:
- Package tercer_nivel_pkg holds:
  - state enum: INIT, IDLE, LOOKUP, EVICT, FILL, FILL_WR, WRITE, RESPOND.
  - sel_mux_mem encodings: MEM_IDLE, MEM_RD, MEM_WR.
  - source enum: SRC_CPU, SRC_FIFO.
- One sub-module, tercer_nivel_arb: the two-requester round-robin arbiter with a last-served flop. It takes a grant-enable input and outputs the grant.

Test Plan:
- Reset, CLR_CYCLES=4 → four clears high for 4 cycles, busy=1; then IDLE with all strobes 0. A Reset asserted mid-FILL returns the block to INIT with no push or cpu_done.
- CPU read, hit=1 at LOOKUP → eneable_main_reg at cycle 0, lectura_escritura=0, eneable_reg and cpu_done at cycle 2.
- CPU read, clean miss → eneable_formador high for cycles 2–5, bank_eneable/write_eneable with sel_mux_bank=1 at cycle 6, hit re-checked at cycle 7, cpu_done at cycle 8.
- FIFO write-back, dirty miss, push_full high for 3 cycles → fifo_pop at cycle 0, EVICT holds for 3 cycles with push=0, then push=1 exactly once; the sequence ends with no cpu_done.
- CPU and FIFO both pending continuously → grants alternate FIFO, CPU, FIFO, CPU; lectura_escritura matches each grant.
- CPU write hit → WRITE at cycle 2 (sel_mux_bank=0, write_eneable=1), cpu_done at cycle 3.
